// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline control sequencer.
// State encodings are visible on state_o, so their values are fixed.
package pipe_ctrl_pkg;

  // Sequencer states; encodings 5..7 are illegal and recover to LOAD
  typedef enum logic [2:0] {
    LOAD  = 3'd0,
    START = 3'd1,
    RUN   = 3'd2,
    DRAIN = 3'd3,
    HALT  = 3'd4
  } state_e;

  localparam int STATE_W = 3;

  // RV32I major opcodes that matter to pipeline control
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  // Width needed to hold a drain count of n-1 (at least one bit)
  function automatic int drain_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pipe_hazard_detect.sv
// Load-use hazard detector. Purely combinational so the forwarding
// logic can reuse the same register-index comparison.
module pipe_hazard_detect
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic             ex_is_load,
  input  logic [REG_W-1:0] ex_rd,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs2,
  output logic             load_use
);

  logic rd_valid;
  logic rs1_match;
  logic rs2_match;

  // x0 is never a real producer, so a load to x0 cannot create a hazard
  always_comb begin
    rd_valid  = (ex_rd != '0);
    rs1_match = rd_valid && (ex_rd == id_rs1);
    rs2_match = rd_valid && id_use_rs2 && (ex_rd == id_rs2);
    load_use  = ex_is_load && (rs1_match || rs2_match);
  end

endmodule

// File: rtl/pipe_ctrl_fsm.sv
// Central pipeline sequencer: program load, hazard stall/flush, halt/drain.
// Optional performance counters are built only when PIPE_CTRL_PERF_CNT_EN
// is defined; otherwise stall_cnt/flush_cnt are tied to zero.
module pipe_ctrl_fsm
  import pipe_ctrl_pkg::*;
#(
  parameter int ADDR_W       = 9,
  parameter int REG_W        = 5,
  parameter int DRAIN_CYCLES = 3,
  parameter int CNT_W        = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ld_we,
  input  logic [ADDR_W-1:0]  ld_addr,
  input  logic               ld_done,
  output logic               imem_we,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [REG_W-1:0]   id_rs1,
  input  logic [REG_W-1:0]   id_rs2,
  input  logic               id_use_rs2,
  input  logic [REG_W-1:0]   ex_rd,
  input  logic               ex_is_load,
  input  logic               ex_redirect,
  input  logic               halt_req,
  output logic               pc_en,
  output logic               ifid_en,
  output logic               ifid_flush,
  output logic               idex_flush,
  output logic               pipe_rst_n,
  output logic [STATE_W-1:0] state_o,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   flush_cnt
);

  localparam int DRAIN_W = drain_width(DRAIN_CYCLES);
  localparam logic [DRAIN_W-1:0] DRAIN_INIT = DRAIN_W'(DRAIN_CYCLES - 1);

  state_e             state_q;
  state_e             state_d;
  logic [DRAIN_W-1:0] drain_q;
  logic [DRAIN_W-1:0] drain_d;
  logic               load_use;

  pipe_hazard_detect #(
    .REG_W (REG_W)
  ) u_hazard (
    .ex_is_load (ex_is_load),
    .ex_rd      (ex_rd),
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .id_use_rs2 (id_use_rs2),
    .load_use   (load_use)
  );

  // The loader address is always passed through; only the strobe is gated
  assign imem_addr = ld_addr;
  assign state_o   = state_q;

  // State and drain-counter registers; reset drops straight back to LOAD
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= LOAD;
      drain_q <= '0;
    end else begin
      state_q <= state_d;
      drain_q <= drain_d;
    end
  end

  // Next-state and output decode; defaults are the safe LOAD-state values
  always_comb begin
    state_d    = state_q;
    drain_d    = drain_q;
    pc_en      = 1'b0;
    ifid_en    = 1'b0;
    ifid_flush = 1'b1;
    idex_flush = 1'b1;
    pipe_rst_n = 1'b0;
    imem_we    = 1'b0;

    case (state_q)
      LOAD: begin
        imem_we = ld_we;
        if (ld_done) begin
          state_d = START;
        end
      end

      START: begin
        pipe_rst_n = 1'b1;
        state_d    = RUN;
      end

      RUN: begin
        pipe_rst_n = 1'b1;
        if (ex_redirect) begin
          pc_en      = 1'b1;
          ifid_en    = 1'b1;
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
        end else if (load_use) begin
          pc_en      = 1'b0;
          ifid_en    = 1'b0;
          ifid_flush = 1'b0;
          idex_flush = 1'b1;
        end else if (halt_req) begin
          pc_en      = 1'b0;
          ifid_en    = 1'b0;
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
          state_d    = DRAIN;
          drain_d    = DRAIN_INIT;
        end else begin
          pc_en      = 1'b1;
          ifid_en    = 1'b1;
          ifid_flush = 1'b0;
          idex_flush = 1'b0;
        end
      end

      DRAIN: begin
        pipe_rst_n = 1'b1;
        if (drain_q == '0) begin
          state_d = HALT;
        end else begin
          drain_d = drain_q - 1'b1;
        end
      end

      HALT: begin
        pipe_rst_n = 1'b1;
        imem_we    = ld_we;
        if (ld_we) begin
          state_d = LOAD;
        end
      end

      default: begin
        state_d = LOAD;
        drain_d = '0;
      end
    endcase
  end

`ifdef PIPE_CTRL_PERF_CNT_EN
  logic             stall_evt;
  logic             flush_evt;
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] flush_q;

  assign stall_evt = (state_q == RUN) && !ex_redirect && load_use;
  assign flush_evt = (state_q == RUN) && ex_redirect;
  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;

  // Saturating event counters, cleared whenever a new program is loading
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else if (state_q == LOAD) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (stall_evt && (stall_q != '1)) begin
        stall_q <= stall_q + 1'b1;
      end
      if (flush_evt && (flush_q != '1)) begin
        flush_q <= flush_q + 1'b1;
      end
    end
  end
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl_fsm.sv
// Self-checking bench for pipe_ctrl_fsm: directed boot/hazard/halt scenarios
// followed by randomized traffic against a behavioural reference model.
module tb_pipe_ctrl_fsm;

  localparam int ADDR_W       = 9;
  localparam int REG_W        = 5;
  localparam int DRAIN_CYCLES = 3;
  localparam int CNT_W        = 16;
  localparam int CNT_MAX      = (1 << CNT_W) - 1;

  logic              clk;
  logic              reset;
  logic              ld_we;
  logic [ADDR_W-1:0] ld_addr;
  logic              ld_done;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [REG_W-1:0]  id_rs1;
  logic [REG_W-1:0]  id_rs2;
  logic              id_use_rs2;
  logic [REG_W-1:0]  ex_rd;
  logic              ex_is_load;
  logic              ex_redirect;
  logic              halt_req;
  logic              pc_en;
  logic              ifid_en;
  logic              ifid_flush;
  logic              idex_flush;
  logic              pipe_rst_n;
  logic [2:0]        state_o;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  int check_total;
  int check_pass;
  int we_seen;

  // Reference model: current mode, remaining drain cycles, event tallies
  int m_state;
  int m_drain_left;
  int m_stall;
  int m_flush;

  pipe_ctrl_fsm #(
    .ADDR_W       (ADDR_W),
    .REG_W        (REG_W),
    .DRAIN_CYCLES (DRAIN_CYCLES),
    .CNT_W        (CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .ld_we       (ld_we),
    .ld_addr     (ld_addr),
    .ld_done     (ld_done),
    .imem_we     (imem_we),
    .imem_addr   (imem_addr),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_use_rs2  (id_use_rs2),
    .ex_rd       (ex_rd),
    .ex_is_load  (ex_is_load),
    .ex_redirect (ex_redirect),
    .halt_req    (halt_req),
    .pc_en       (pc_en),
    .ifid_en     (ifid_en),
    .ifid_flush  (ifid_flush),
    .idex_flush  (idex_flush),
    .pipe_rst_n  (pipe_rst_n),
    .state_o     (state_o),
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_total++;
    if (obs !== exp) begin
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end else begin
      check_pass++;
    end
  endtask

  function automatic int exp_stall();
`ifdef PIPE_CTRL_PERF_CNT_EN
    return m_stall;
`else
    return 0;
`endif
  endfunction

  function automatic int exp_flush();
`ifdef PIPE_CTRL_PERF_CNT_EN
    return m_flush;
`else
    return 0;
`endif
  endfunction

  // Compare all outputs against the model, then advance the model by one clock
  task automatic checkCycle();
    bit hazard;
    bit e_pc, e_ifen, e_iff, e_idf, e_prst, e_we, chk_ifen;
    hazard = ex_is_load && (ex_rd != 0) &&
             ((ex_rd == id_rs1) || (id_use_rs2 && (ex_rd == id_rs2)));
    e_pc = 0; e_ifen = 0; e_iff = 1; e_idf = 1; e_prst = 1; e_we = 0; chk_ifen = 0;
    case (m_state)
      0: begin e_prst = 0; e_we = ld_we; chk_ifen = 1; end
      2: begin
        if (ex_redirect) begin
          e_pc = 1; e_ifen = 1; chk_ifen = 1;
        end else if (hazard) begin
          e_iff = 0; chk_ifen = 1;
        end else if (!halt_req) begin
          e_pc = 1; e_ifen = 1; e_iff = 0; e_idf = 0; chk_ifen = 1;
        end
      end
      4: e_we = ld_we;
      default: ;
    endcase

    checkOutput("state_o", 32'(state_o), 32'(m_state));
    checkOutput("pc_en", 32'(pc_en), 32'(e_pc));
    if (chk_ifen) checkOutput("ifid_en", 32'(ifid_en), 32'(e_ifen));
    checkOutput("ifid_flush", 32'(ifid_flush), 32'(e_iff));
    checkOutput("idex_flush", 32'(idex_flush), 32'(e_idf));
    checkOutput("pipe_rst_n", 32'(pipe_rst_n), 32'(e_prst));
    checkOutput("imem_we", 32'(imem_we), 32'(e_we));
    if (e_we) checkOutput("imem_addr", 32'(imem_addr), 32'(ld_addr));
    checkOutput("stall_cnt", 32'(stall_cnt), 32'(exp_stall()));
    checkOutput("flush_cnt", 32'(flush_cnt), 32'(exp_flush()));
    if (imem_we) we_seen++;

    case (m_state)
      0: begin
        m_stall = 0;
        m_flush = 0;
        if (ld_done) m_state = 1;
      end
      1: m_state = 2;
      2: begin
        if (ex_redirect) begin
          if (m_flush < CNT_MAX) m_flush++;
        end else if (hazard) begin
          if (m_stall < CNT_MAX) m_stall++;
        end else if (halt_req) begin
          m_state      = 3;
          m_drain_left = DRAIN_CYCLES;
        end
      end
      3: begin
        m_drain_left--;
        if (m_drain_left == 0) m_state = 4;
      end
      4: if (ld_we) m_state = 0;
      default: m_state = 0;
    endcase
  endtask

  task automatic applyStimulus(input bit we, input int addr, input bit done,
                               input int rs1, input int rs2, input bit use2,
                               input int rd, input bit is_load, input bit redir,
                               input bit halt);
    @(negedge clk);
    ld_we       = we;
    ld_addr     = ADDR_W'(addr);
    ld_done     = done;
    id_rs1      = REG_W'(rs1);
    id_rs2      = REG_W'(rs2);
    id_use_rs2  = use2;
    ex_rd       = REG_W'(rd);
    ex_is_load  = is_load;
    ex_redirect = redir;
    halt_req    = halt;
    #1;
    checkCycle();
  endtask

  task automatic applyRandom(input bit allow_halt);
    applyStimulus($urandom_range(0, 2) == 0, $urandom_range(0, 511), $urandom_range(0, 7) == 0,
                  $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1) == 1,
                  $urandom_range(0, 3), $urandom_range(0, 1) == 1, $urandom_range(0, 4) == 0,
                  allow_halt && ($urandom_range(0, 15) == 0));
  endtask

  initial begin
    int drain_seen;
    check_total  = 0;
    check_pass   = 0;
    we_seen      = 0;
    m_state      = 0;
    m_drain_left = 0;
    m_stall      = 0;
    m_flush      = 0;
    reset = 1'b0; ld_we = 0; ld_addr = '0; ld_done = 0; id_rs1 = '0; id_rs2 = '0;
    id_use_rs2 = 0; ex_rd = '0; ex_is_load = 0; ex_redirect = 0; halt_req = 0;

    // Reset held low for two cycles
    repeat (2) @(negedge clk);
    #1;
    checkOutput("rst_state", 32'(state_o), 32'd0);
    checkOutput("rst_pc_en", 32'(pc_en), 32'd0);
    checkOutput("rst_ifid_en", 32'(ifid_en), 32'd0);
    checkOutput("rst_ifid_flush", 32'(ifid_flush), 32'd1);
    checkOutput("rst_idex_flush", 32'(idex_flush), 32'd1);
    checkOutput("rst_pipe_rst_n", 32'(pipe_rst_n), 32'd0);
    checkOutput("rst_imem_we", 32'(imem_we), 32'd0);
    reset = 1'b1;

    // Boot: four writes then the completion pulse
    we_seen = 0;
    for (int i = 0; i < 4; i++) applyStimulus(1, i, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("boot_we_cycles", 32'(we_seen), 32'd4);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("boot_start_state", 32'(state_o), 32'd1);
    checkOutput("boot_pipe_rst_rise", 32'(pipe_rst_n), 32'd1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("boot_run_state", 32'(state_o), 32'd2);

    // Load-use stall and its non-stalling neighbours
    applyStimulus(0, 0, 0, 5, 0, 0, 5, 1, 0, 0);
    checkOutput("lu_pc_en", 32'(pc_en), 32'd0);
    applyStimulus(0, 0, 0, 5, 0, 0, 5, 0, 0, 0);
    checkOutput("lu_next_pc_en", 32'(pc_en), 32'd1);
    applyStimulus(0, 0, 0, 0, 0, 1, 0, 1, 0, 0);
    checkOutput("lu_x0_pc_en", 32'(pc_en), 32'd1);
    applyStimulus(0, 0, 0, 1, 5, 0, 5, 1, 0, 0);
    checkOutput("lu_rs2_unused_pc_en", 32'(pc_en), 32'd1);
    applyStimulus(0, 0, 0, 1, 5, 1, 5, 1, 0, 0);

    // Redirect beats load-use; then redirect squashes a halt
    applyStimulus(0, 0, 0, 5, 0, 0, 5, 1, 1, 0);
    checkOutput("redir_lu_pc_en", 32'(pc_en), 32'd1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("redir_halt_no_drain", 32'(state_o), 32'd2);

    // Halt and drain; redirects and loader traffic ignored meanwhile
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    drain_seen = 0;
    for (int k = 0; k < 10; k++) begin
      applyStimulus(0, 0, $urandom_range(0, 1) == 1, 0, 0, 0, 0, 0, $urandom_range(0, 1) == 1, 0);
      if (state_o == 3'd3) drain_seen++;
      if (state_o == 3'd4) break;
    end
    checkOutput("drain_len", 32'(drain_seen), 32'(DRAIN_CYCLES));
    checkOutput("halt_reached", 32'(state_o), 32'd4);
    applyStimulus(1, 9, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("halt_exit_we", 32'(imem_we), 32'd1);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("halt_exit_load", 32'(state_o), 32'd0);

    // Randomized traffic through all modes
    applyStimulus(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
    for (int n = 0; n < 1500; n++) applyRandom(1'b1);

    // Steer back into RUN, build up counts, then reset asynchronously
    for (int n = 0; n < 20 && m_state != 2; n++) begin
      applyStimulus(m_state == 4, 0, m_state == 0, 0, 0, 0, 0, 0, 0, 0);
    end
    checkOutput("pre_reset_run", 32'(state_o), 32'd2);
    for (int n = 0; n < 8; n++) applyRandom(1'b0);
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    m_state = 0; m_stall = 0; m_flush = 0; m_drain_left = 0;
    checkOutput("arst_state", 32'(state_o), 32'd0);
    checkOutput("arst_pc_en", 32'(pc_en), 32'd0);
    checkOutput("arst_ifid_flush", 32'(ifid_flush), 32'd1);
    checkOutput("arst_idex_flush", 32'(idex_flush), 32'd1);
    checkOutput("arst_pipe_rst_n", 32'(pipe_rst_n), 32'd0);
    checkOutput("arst_stall_cnt", 32'(stall_cnt), 32'd0);
    checkOutput("arst_flush_cnt", 32'(flush_cnt), 32'd0);
    #1 reset = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", check_pass, check_total);
    $finish;
  end

endmodule
